// File: rtl/axrm_pipe_nxn.sv
// Pipelined N x N unsigned approximate recursive multiplier built from 2x2 digit products.
// The low a-digit rows may replace 3x3 with 7; a saturating counter tracks delivered hits.
module axrm_pipe_nxn #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EXACT_ROWS = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               out_exact,
    output logic [CNT_W-1:0]   hit_count,
    input  logic               clr_count
);

    localparam int unsigned D     = WIDTH / 2;
    localparam int          AROWS = int'(D) - int'(EXACT_ROWS);
    localparam int unsigned HW    = $clog2(D * D + 1);
    // A row sum is at most 3 * (2^WIDTH - 1), so two extra bits suffice.
    localparam int unsigned RW    = WIDTH + 2;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned SW    = ((CNT_W > HW) ? CNT_W : HW) + 1;

    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;

    // Stage 1: captured operands
    logic [WIDTH-1:0] a_q, b_q;
    logic             en_q;

    // Stage 2: per-row partial sums and hit count
    logic [RW-1:0] row_d [D];
    logic [RW-1:0] row_q [D];
    logic [HW-1:0] hits2_d, hits2_q;
    logic [3:0]    pp;

    // Stage 3: final product
    logic [PW-1:0] res_d, res_q;
    logic          exact_d, exact_q;
    logic [HW-1:0] hits3_q;

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SW-1:0]    cnt_sum;

    assign adv3     = !v3_q || out_ready;
    assign adv2     = !v2_q || adv3;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            en_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_q  <= b;
                en_q <= approx_en;
            end
        end
    end

    always_comb begin
        pp      = '0;
        hits2_d = '0;
        for (int i = 0; i < int'(D); i++) begin
            row_d[i] = '0;
            for (int j = 0; j < int'(D); j++) begin
                pp = {2'b00, a_q[2*i +: 2]} * {2'b00, b_q[2*j +: 2]};
                if (en_q && (i < AROWS) && (a_q[2*i +: 2] == 2'b11)
                    && (b_q[2*j +: 2] == 2'b11)) begin
                    pp      = 4'b0111;
                    hits2_d = hits2_d + HW'(1);
                end
                row_d[i] = row_d[i] + (RW'(pp) << (2 * j));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            hits2_q <= '0;
            for (int i = 0; i < int'(D); i++) begin
                row_q[i] <= '0;
            end
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                hits2_q <= hits2_d;
                for (int i = 0; i < int'(D); i++) begin
                    row_q[i] <= row_d[i];
                end
            end
        end
    end

    always_comb begin
        res_d = '0;
        for (int i = 0; i < int'(D); i++) begin
            res_d = res_d + (PW'(row_q[i]) << (2 * i));
        end
        exact_d = (hits2_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q    <= 1'b0;
            res_q   <= '0;
            exact_q <= 1'b0;
            hits3_q <= '0;
        end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                res_q   <= res_d;
                exact_q <= exact_d;
                hits3_q <= hits2_q;
            end
        end
    end

    always_comb begin
        cnt_sum = SW'(cnt_q) + SW'(hits3_q);
        cnt_d   = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (v3_q && out_ready) begin
            if (cnt_sum > SW'({CNT_W{1'b1}})) begin
                cnt_d = '1;
            end else begin
                cnt_d = cnt_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = res_q;
    assign out_exact = exact_q;
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_axrm_pipe_nxn.sv
// Randomised bench for axrm_pipe_nxn: scoreboard against an arithmetic error model,
// plus directed literal cases, stall, async reset and counter saturation.
module tb_axrm_pipe_nxn;

    localparam int W  = 8;
    localparam int D  = W / 2;
    localparam int ER = 1;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0, approx_en = 1'b0, out_ready = 1'b1, clr_count = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           in_ready, out_valid, out_exact;
    logic [2*W-1:0] result;
    logic [CW-1:0]  hit_count;

    logic           iv4 = 1'b0, en4 = 1'b0, or4 = 1'b1, clr4 = 1'b0;
    logic [W-1:0]   a4 = '0, b4 = '0;
    logic           ir4, ov4, ex4;
    logic [2*W-1:0] res4;
    logic [3:0]     hit4;

    axrm_pipe_nxn dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_exact(out_exact), .hit_count(hit_count), .clr_count(clr_count)
    );

    axrm_pipe_nxn #(.WIDTH(8), .EXACT_ROWS(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .approx_en(en4), .out_valid(ov4), .out_ready(or4),
        .result(res4), .out_exact(ex4), .hit_count(hit4), .clr_count(clr4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_out  = 0;
    logic lat_chk = 1'b0;
    logic done    = 1'b0;

    typedef struct {
        logic [2*W-1:0] r;
        logic           ex;
        int             h;
        int             t;
    } exp_t;
    exp_t q[$];

    int             cnt_model = 0;
    logic           prev_stall = 1'b0;
    logic [2*W-1:0] prev_r = '0;
    logic           prev_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Approximate product = exact product minus 2*4^(i+j) for every replaced 3x3 digit pair.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic en, output logic [2*W-1:0] r, output int h);
        r = (2*W)'(x) * (2*W)'(y);
        h = 0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (en && (i < D - ER) && (x[2*i +: 2] == 2'b11) && (y[2*j +: 2] == 2'b11)) begin
                    h++;
                    r = r - (2*W)'(2 * (4 ** (i + j)));
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t           e;
        logic [2*W-1:0] mr;
        int             mh;
        int             add;
        logic           xfer;
        if (rst) begin
            q.delete();
            cnt_model  = 0;
            prev_stall = 1'b0;
        end else begin
            add  = 0;
            xfer = 1'b0;
            chk("hit_count", hit_count, cnt_model);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_result", result, prev_r);
                chk("stall_exact", out_exact, prev_e);
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = result;
            prev_e     = out_exact;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("out_exact", out_exact, e.ex);
                    if (lat_chk) chk("latency", cyc - e.t, 3);
                    n_out++;
                    add  = e.h;
                    xfer = 1'b1;
                end
            end
            if (clr_count) cnt_model = 0;
            else if (xfer) cnt_model = (cnt_model + add > 2 ** CW - 1) ? 2 ** CW - 1
                                                                       : cnt_model + add;
            if (in_valid && in_ready) begin
                model(a, b, approx_en, mr, mh);
                q.push_back('{r: mr, ex: (mh == 0), h: mh, t: cyc});
                n_acc++;
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic en);
        int k;
        a = x;
        b = y;
        approx_en = en;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic en,
                            input logic [2*W-1:0] er, input logic ee, input int ec);
        int k;
        send(x, y, en);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        chk("dir_latency", k, 3);
        chk("dir_result", result, er);
        chk("dir_exact", out_exact, ee);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dir_hit_count", hit_count, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*W-1:0] mr;
        int             mh;
        int             c0, acc0, out0, k;
        int             exp4[3];
        exp4 = '{12, 15, 0};

        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_exact", out_exact, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_hit_count4", hit4, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        model(8'hFF, 8'hFF, 1'b1, mr, mh);
        chk("model_ff_r", mr, 16'hF00F);
        chk("model_ff_h", mh, 12);
        model(8'hC0, 8'hFF, 1'b1, mr, mh);
        chk("model_c0_r", mr, 16'hBF40);

        lat_chk = 1'b1;
        directed(8'h03, 8'h03, 1'b1, 16'h0007, 1'b0, 1);
        directed(8'hFF, 8'hFF, 1'b1, 16'hF00F, 1'b0, 13);
        directed(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 13);
        directed(8'hC0, 8'hFF, 1'b1, 16'hBF40, 1'b1, 13);

        // back-to-back random operands, no backpressure
        c0 = cyc;
        for (int n = 0; n < 100; n++)
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
        chk("throughput", cyc - c0, 100);
        drain();
        lat_chk = 1'b0;

        // stall: 5 transactions, out_ready low for 6 cycles
        acc0 = n_acc;
        out0 = n_out;
        out_ready = 1'b0;
        fork
            for (int n = 0; n < 5; n++) send(W'($urandom), W'($urandom), 1'b1);
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("stall_accepted", n_acc - acc0, 3);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_delivered", n_out - out0, 5);

        // random valid gaps and random backpressure
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with two transactions in flight
        send(8'hFF, 8'hFF, 1'b1);
        send(8'hFF, 8'hFF, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_exact", out_exact, 0);
        chk("arst_hit_count", hit_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("arst_quiet", out_valid, 0);
        end
        chk("arst_in_ready", in_ready, 1);

        // 4-bit counter saturation and clear-wins-over-increment
        @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) begin
            a4 = 8'hFF;
            b4 = 8'hFF;
            en4 = 1'b1;
            iv4 = 1'b1;
            @(negedge clk);
            chk("cnt4_in_ready", ir4, 1);
            @(posedge clk);
            #1 iv4 = 1'b0;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!ov4 && k < 10);
            chk("cnt4_valid", ov4, 1);
            chk("cnt4_result", res4, 16'hF00F);
            if (t == 2) clr4 = 1'b1;
            @(posedge clk);
            #1 clr4 = 1'b0;
            @(negedge clk);
            chk("cnt4_hit_count", hit4, exp4[t]);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
